// File: rtl/xgmii_rx_frame_ctrl_pkg.sv
// Shared types and constants for the XGMII receive frame controller.
// Decoder status codes, control characters, frame states and the beat record.
package xgmii_rx_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_DATA  = 2'b00,
    ST_START = 2'b01,
    ST_TERM  = 2'b10,
    ST_OTHER = 2'b11
  } rx_st_e;

  localparam logic [7:0] CTRL_START    = 8'hFB;
  localparam logic [7:0] CTRL_TERM     = 8'hFD;
  localparam logic [7:0] CTRL_IDLE     = 8'h07;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_DEFAULT   = 8'hD5;

  typedef enum logic [1:0] {
    FS_IDLE = 2'b00,
    FS_DATA = 2'b01,
    FS_DROP = 2'b10
  } frame_state_e;

  // One payload beat; also the shape of the single-word hold stage.
  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic        sof;
    logic        eof;
    logic [7:0]  be;
    logic        err;
    logic [15:0] len;
  } beat_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/xgmii_rx_frame_ctrl_if.sv
// Decoder-side word stream and MAC-side beat stream of the frame controller.
interface xgmii_rx_frame_ctrl_if;
  logic [1:0]  RX_DATA_ST;
  logic [63:0] PLS_DATA;
  logic [7:0]  RXC;
  logic [63:0] RX_DATA;
  logic        RX_VALID;
  logic        RX_SOF;
  logic        RX_EOF;
  logic [7:0]  RX_BE;
  logic        RX_ERR;
  logic [15:0] RX_LEN;

  modport master (
    output RX_DATA_ST, PLS_DATA, RXC,
    input  RX_DATA, RX_VALID, RX_SOF, RX_EOF, RX_BE, RX_ERR, RX_LEN
  );

  modport slave (
    input  RX_DATA_ST, PLS_DATA, RXC,
    output RX_DATA, RX_VALID, RX_SOF, RX_EOF, RX_BE, RX_ERR, RX_LEN
  );
endinterface

// File: rtl/xgmii_term_lane_enc.sv
// Locates the terminate lane from the raw RXC mask and builds the tail byte enables.
// A mask that is not of the form 8'hFF<<k is flagged invalid.
module xgmii_term_lane_enc (
  input  logic [7:0] rxc_i,
  output logic [2:0] lane_o,
  output logic       valid_o,
  output logic [7:0] be_o
);

  always_comb begin
    casez (rxc_i)
      8'b???????1: lane_o = 3'd0;
      8'b??????10: lane_o = 3'd1;
      8'b?????100: lane_o = 3'd2;
      8'b????1000: lane_o = 3'd3;
      8'b???10000: lane_o = 3'd4;
      8'b??100000: lane_o = 3'd5;
      8'b?1000000: lane_o = 3'd6;
      8'b10000000: lane_o = 3'd7;
      default:     lane_o = 3'd0;
    endcase
  end

  assign valid_o = (rxc_i == (8'hFF << lane_o));
  assign be_o    = (8'h01 << lane_o) - 8'h01;

endmodule

// File: rtl/xgmii_rx_frame_ctrl.sv
// Turns decoded XGMII words into SOF/EOF-delimited payload beats through a one-word
// hold stage, checks SFD and length, and counts good and bad frames.
module xgmii_rx_frame_ctrl
  import xgmii_rx_frame_ctrl_pkg::*;
#(
  parameter logic [15:0] MIN_LEN  = 16'd64,
  parameter logic [15:0] MAX_LEN  = 16'd1518,
  parameter logic [7:0]  SFD_BYTE = SFD_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RST,
  xgmii_rx_frame_ctrl_if.slave        bus,
  output logic [31:0]                 FRAMES_OK,
  output logic [31:0]                 FRAMES_BAD
);

  frame_state_e state_q, state_d;
  beat_t        hold_q, hold_d;
  beat_t        beat_q, beat_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         sof_pend_q, sof_pend_d;
  logic [31:0]  ok_q, bad_q;
  logic         ok_inc_s;
  logic [1:0]   bad_inc_s;

  rx_st_e       st_s;
  logic         sfd_ok_s;
  logic         push_s, term_full_s, term_part_s, abort_s, start_s;
  logic [2:0]   term_k_s;
  logic         term_vld_s;
  logic [7:0]   term_be_s;
  logic [15:0]  term_len_s;

  function automatic logic len_bad(input logic [15:0] n);
    return (n < MIN_LEN) || (n > MAX_LEN);
  endfunction

  xgmii_term_lane_enc u_term_enc (
    .rxc_i   (bus.RXC),
    .lane_o  (term_k_s),
    .valid_o (term_vld_s),
    .be_o    (term_be_s)
  );

  assign st_s       = rx_st_e'(bus.RX_DATA_ST);
  assign sfd_ok_s   = (bus.PLS_DATA[63:56] == SFD_BYTE);
  assign term_len_s = sat_add16(cnt_q, {1'b0, term_k_s});

  // A start always (re)opens a frame; inside DATA it first aborts the open one.
  always_comb begin
    push_s      = 1'b0;
    term_full_s = 1'b0;
    term_part_s = 1'b0;
    abort_s     = 1'b0;
    start_s     = 1'b0;
    case (state_q)
      FS_DATA: begin
        case (st_s)
          ST_DATA:  push_s = 1'b1;
          ST_TERM: begin
            if (!term_vld_s)            abort_s     = 1'b1;
            else if (term_k_s == 3'd0)  term_full_s = 1'b1;
            else                        term_part_s = 1'b1;
          end
          ST_START: begin
            abort_s = 1'b1;
            start_s = 1'b1;
          end
          default:  abort_s = 1'b1;
        endcase
      end
      FS_IDLE, FS_DROP: start_s = (st_s == ST_START);
      default:          start_s = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= FS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = sfd_ok_s ? FS_DATA : FS_DROP;
    end else if (state_q == FS_DATA) begin
      state_d = push_s ? FS_DATA : FS_IDLE;
    end else if (state_q == FS_DROP) begin
      state_d = ((st_s == ST_TERM) || (st_s == ST_OTHER)) ? FS_IDLE : FS_DROP;
    end else begin
      state_d = FS_IDLE;
    end
  end

  // Whatever sits in hold always leaves this cycle; only the EOF marking depends on the input.
  always_comb begin
    hold_d     = '0;
    cnt_d      = cnt_q;
    sof_pend_d = sof_pend_q;
    ok_inc_s   = 1'b0;
    bad_inc_s  = 2'd0;
    beat_d     = hold_q.valid ? hold_q : '0;

    if (push_s) begin
      hold_d     = '{valid: 1'b1, data: bus.PLS_DATA, sof: sof_pend_q, eof: 1'b0,
                     be: 8'hFF, err: 1'b0, len: 16'd0};
      cnt_d      = sat_add16(cnt_q, 4'd8);
      sof_pend_d = 1'b0;
    end

    if (term_part_s) begin
      hold_d     = '{valid: 1'b1, data: bus.PLS_DATA, sof: sof_pend_q, eof: 1'b1,
                     be: term_be_s, err: len_bad(term_len_s), len: term_len_s};
      cnt_d      = term_len_s;
      sof_pend_d = 1'b0;
    end

    if (term_full_s || abort_s) begin
      if (hold_q.valid) begin
        beat_d.eof = 1'b1;
        beat_d.len = cnt_q;
        beat_d.err = abort_s || len_bad(cnt_q);
      end else begin
        bad_inc_s = bad_inc_s + 2'd1;
      end
    end

    if (start_s) begin
      cnt_d      = 16'd0;
      sof_pend_d = sfd_ok_s;
      if (!sfd_ok_s) bad_inc_s = bad_inc_s + 2'd1;
    end

    if (beat_d.valid && beat_d.eof) begin
      if (beat_d.err) bad_inc_s = bad_inc_s + 2'd1;
      else            ok_inc_s  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q     <= '0;
      beat_q     <= '0;
      cnt_q      <= 16'd0;
      sof_pend_q <= 1'b0;
      ok_q       <= 32'd0;
      bad_q      <= 32'd0;
    end else begin
      hold_q     <= hold_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      sof_pend_q <= sof_pend_d;
      ok_q       <= ok_q + {31'd0, ok_inc_s};
      bad_q      <= bad_q + {30'd0, bad_inc_s};
    end
  end

  assign bus.RX_DATA  = beat_q.data;
  assign bus.RX_VALID = beat_q.valid;
  assign bus.RX_SOF   = beat_q.sof;
  assign bus.RX_EOF   = beat_q.eof;
  assign bus.RX_BE    = beat_q.be;
  assign bus.RX_ERR   = beat_q.err;
  assign bus.RX_LEN   = beat_q.len;
  assign FRAMES_OK    = ok_q;
  assign FRAMES_BAD   = bad_q;

endmodule

// File: doc/xgmii_rx_frame_ctrl.md
Name: xgmii_rx_frame_ctrl

Overview:
- Sequences the per-word output of the XGMII control-character decoder (PLS_DATA / RX_DATA_ST, with raw RXC) into delimited frame beats.
- Tracks frame state, strips the preamble/SFD word, and produces per-beat SOF, EOF and byte enables.
- Checks SFD and frame length, and keeps good/bad frame counters.
- Sits between the decoder and the MAC receive FIFO.

Parameters:
MIN_LEN, 64, minimum legal payload+FCS length in bytes
MAX_LEN, 1518, maximum legal payload+FCS length in bytes
SFD_BYTE, 8'hD5, expected value of lane 7 of the start word

Ports:
CLK  in  1  single clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
RX_DATA_ST  in  2  decoder status: 00 data, 01 start, 10 terminate, 11 other/idle/error
PLS_DATA  in  64  decoder data, lane 0 = bits 7:0
RXC  in  8  raw XGMII control mask, used to locate the terminate lane
RX_DATA  out  64  payload beat
RX_VALID  out  1  beat valid
RX_SOF  out  1  first beat of a frame
RX_EOF  out  1  last beat of a frame
RX_BE  out  8  byte enables; 8'hFF except on EOF beat
RX_ERR  out  1  set on EOF beat when the frame is bad
RX_LEN  out  16  frame byte count; valid on EOF beat
FRAMES_OK  out  32  good-frame counter, wraps
FRAMES_BAD  out  32  bad-frame counter, wraps

Behaviour:
- Reset: RST=1 at an edge clears all of the following, with no EOF emitted for a partial frame:
  - state=IDLE, hold stage empty, byte counter 0.
  - All outputs 0: RX_DATA, RX_VALID, RX_SOF, RX_EOF, RX_BE, RX_ERR, RX_LEN, FRAMES_OK, FRAMES_BAD.
- Pipeline: a one-word hold register (data, sof flag, eof flag, be) feeds registered outputs.
  - Every payload word appears on RX_DATA exactly 2 cycles after it is on PLS_DATA.
  - RX_VALID=0 in cycles with no beat; RX_SOF, RX_EOF and RX_ERR are meaningful only when RX_VALID=1.
- States: IDLE, DATA, DROP.
- IDLE:
  - Status 01 with PLS_DATA[63:56]==SFD_BYTE -> DATA; the start word is not forwarded; next payload word is flagged sof.
  - Status 01 with SFD mismatch -> DROP; FRAMES_BAD++.
  - Statuses 00, 10 and 11 are ignored.
- DATA:
  - Status 00: push word into hold; the previous hold content goes out as a non-EOF beat; counter += 8.
  - Status 10, terminate lane k = number of trailing zeros of RXC (RXC == 8'hFF<<k, k in 0..7):
    - k=0: hold content goes out as the EOF beat with BE=8'hFF.
    - k>0: hold content goes out as a normal beat; the terminate word enters hold with eof, BE=(1<<k)-1, counter += k; it is emitted next cycle regardless of input.
    - Either way -> IDLE.
  - Status 11: abort; hold content goes out as EOF with RX_ERR=1; -> IDLE.
  - Status 01 (start inside frame): abort the current frame exactly as for status 11, then re-evaluate as IDLE-start in the same cycle; the new frame's first payload word carries SOF.
- DROP: discard everything until status 10 or 11 -> IDLE. Status 01 in DROP is treated as a new start.
- Length: 16-bit byte counter, saturating at 16'hFFFF.
  - On EOF: RX_LEN=counter; RX_ERR=1 if counter<MIN_LEN or counter>MAX_LEN or aborted.
  - FRAMES_OK++ if RX_ERR=0, else FRAMES_BAD++.
- Empty frame: terminate k=0 or abort while hold is empty. No beat is emitted; FRAMES_BAD++.
- A frame where SOF and EOF land on the same beat (single payload word) is legal output; RX_ERR is set by the length rule.
- Back-to-back frames (a terminate word followed immediately by a start) must not lose or merge beats.

Decomposition:
- Shared package xgmii_pkg:
  - RX_DATA_ST encodings: ST_DATA, ST_START, ST_TERM, ST_OTHER.
  - Control characters: 8'hFB start, 8'hFD terminate, 8'h07 idle.
  - Preamble byte 8'h55 and SFD 8'hD5.
  - Frame-state enum.
- One natural sub-module: xgmii_term_lane_enc (RXC -> lane k 3 bits, valid flag, BE mask); purely combinational.

Test Plan:
1. Start (lane7=D5), 8 data words, terminate RXC=FF -> 8 beats, SOF on beat 1, EOF on beat 8, BE=FF, RX_LEN=64, RX_ERR=0, FRAMES_OK=1.
2. Start, 8 data words, terminate RXC=F8 (k=3) -> 9 beats, last BE=07, RX_LEN=67, RX_ERR=0; first beat appears 2 cycles after first data word.
3. Runt: start, 2 data words, terminate RXC=FF -> 2 beats, EOF on beat 2, RX_LEN=16, RX_ERR=1, FRAMES_BAD=1.
4. Abort: start, 4 data words, status 11 -> beat 4 has EOF=1, ERR=1, BE=FF; FRAMES_BAD=1; the following good frame is delivered intact.
5. Bad SFD (lane7=55), then 8 data words and terminate -> no beats; FRAMES_BAD=1; state IDLE after terminate.
6. RST=1 for one cycle after beat 3 of a 64-byte frame -> RX_VALID=0 next cycle, counters 0; the remaining words are ignored until the next start; the next good frame is delivered with SOF and FRAMES_OK=1.
